muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/mips_pkg.sv | 34 +++
 rtl/muldiv.sv | 176 +++++++++++++++++
 tb/tb_muldiv.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: HI/LO funct codes, muldiv op encodings and FSM state enum.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_RUN   = 2'd1,
        MD_FIXUP = 2'd2
    } md_state_e;

    function automatic logic md_op_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    function automatic logic md_op_is_div(input md_op_e o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Divide datapath is present only when MULDIV_DIV_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MD_IDLE  | waiting; mthi/mtlo write HI/LO, start latches operands
// MD_RUN   | WORD_SIZE radix-2 steps, counter counts down to zero
// MD_FIXUP | sign correction, HI/LO written, done pulsed
module muldiv
    import mips_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] rs_data,
    input  logic [WORD_SIZE-1:0] rt_data,
    input  logic                 mthi,
    input  logic                 mtlo,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int               CNT_W    = $clog2(WORD_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORD_SIZE);

    md_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] ql;
    logic [WORD_SIZE-1:0] bm;
    logic                 sign_a;
    logic                 sign_b;
`ifdef MULDIV_DIV_EN
    logic                 is_div;
    logic                 div_zero;
`endif

    function automatic logic [WORD_SIZE-1:0] neg_w(input logic [WORD_SIZE-1:0] x);
        return ~x + WORD_SIZE'(1);
    endfunction

    md_op_e               op_in;
    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic                 op_ok;
    logic [WORD_SIZE-1:0] a_mag;
    logic [WORD_SIZE-1:0] b_mag;

    assign op_in     = md_op_e'(op);
    assign op_signed = md_op_signed(op_in);
    assign a_neg     = op_signed & rs_data[WORD_SIZE-1];
    assign b_neg     = op_signed & rt_data[WORD_SIZE-1];
    assign a_mag     = a_neg ? neg_w(rs_data) : rs_data;
    assign b_mag     = b_neg ? neg_w(rt_data) : rt_data;
`ifdef MULDIV_DIV_EN
    assign op_ok     = 1'b1;
`else
    assign op_ok     = !md_op_is_div(op_in);
`endif

    assign busy = (state != MD_IDLE);

    // multiply: acc holds the running upper half, ql shifts the multiplier out and product bits in
    logic [WORD_SIZE:0] mul_sum;
    assign mul_sum = {1'b0, acc} + (ql[0] ? {1'b0, bm} : '0);

`ifdef MULDIV_DIV_EN
    // divide: acc is the partial remainder, ql shifts the dividend out and quotient bits in
    logic [WORD_SIZE:0] div_shift;
    logic [WORD_SIZE:0] div_diff;
    assign div_shift = {acc, ql[WORD_SIZE-1]};
    assign div_diff  = div_shift - {1'b0, bm};
`endif

    logic [2*WORD_SIZE-1:0] prod_raw;
    logic [2*WORD_SIZE-1:0] prod_fix;
    logic [WORD_SIZE-1:0]   res_hi;
    logic [WORD_SIZE-1:0]   res_lo;

    assign prod_raw = {acc, ql};

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~prod_raw + (2*WORD_SIZE)'(1)) : prod_raw;
        res_hi   = prod_fix[2*WORD_SIZE-1:WORD_SIZE];
        res_lo   = prod_fix[WORD_SIZE-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            // with a zero divisor the remainder path already reproduces rs_data
            res_hi = sign_a ? neg_w(acc) : acc;
            res_lo = div_zero ? '1 : ((sign_a ^ sign_b) ? neg_w(ql) : ql);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            ql       <= '0;
            bm       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div   <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (mthi) hi <= rs_data;
                    if (mtlo) lo <= rs_data;
                    if (start && op_ok) begin
                        sign_a   <= a_neg;
                        sign_b   <= b_neg;
                        ql       <= a_mag;
                        bm       <= b_mag;
                        acc      <= '0;
                        cnt      <= CNT_LOAD;
`ifdef MULDIV_DIV_EN
                        is_div   <= md_op_is_div(op_in);
                        div_zero <= (rt_data == '0);
`endif
                        state    <= MD_RUN;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                MD_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            if (!div_diff[WORD_SIZE]) begin
                                acc <= div_diff[WORD_SIZE-1:0];
                                ql  <= {ql[WORD_SIZE-2:0], 1'b1};
                            end else begin
                                acc <= div_shift[WORD_SIZE-1:0];
                                ql  <= {ql[WORD_SIZE-2:0], 1'b0};
                            end
                        end else begin
                            acc <= mul_sum[WORD_SIZE:1];
                            ql  <= {mul_sum[0], ql[WORD_SIZE-1:1]};
                        end
`else
                        acc <= mul_sum[WORD_SIZE:1];
                        ql  <= {mul_sum[0], ql[WORD_SIZE-1:1]};
`endif
                    end else begin
                        state <= MD_FIXUP;
                    end
                end
                MD_FIXUP: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_muldiv;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv #(.WORD_SIZE(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Expected HI/LO and start-edge-to-done latency from plain arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi_in, input logic [31:0] lo_in,
                                  output logic [31:0] eh, output logic [31:0] el, output int elat);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned up;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        eh   = hi_in;
        el   = lo_in;
        elat = LAT;
        case (o)
            2'd0: begin
                sp = sa * sb;
                eh = sp[63:32];
                el = sp[31:0];
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (o == 2'd2) begin
                    sp = sa / sb;
                    el = sp[31:0];
                    sp = sa % sb;
                    eh = sp[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
`else
                elat = 0;
`endif
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'(32'($urandom_range(0, 40)) - 32'd20);
            default: return $urandom();
        endcase
    endfunction

    // Issue one op and wait (bounded) for done. lat = edges after the start edge, -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic with_mthi, input logic with_mtlo,
                          input int poke_k, input logic p_start, input logic p_mthi,
                          output int lat, output logic [31:0] rh, output logic [31:0] rl,
                          output logic [31:0] h_pre, output logic [31:0] l_pre, output logic [31:0] h0,
                          output logic busy_ok, output logic stable);
        logic [31:0] l0;
        @(negedge clk);
        h_pre   = hi;
        l_pre   = lo;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        mthi    = with_mthi;
        mtlo    = with_mtlo;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        stable  = 1'b1;
        h0      = hi;
        l0      = lo;
        rh      = hi;
        rl      = lo;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = k;
                rh  = hi;
                rl  = lo;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            if (k == poke_k) begin
                start   = p_start;
                mthi    = p_mthi;
                op      = o ^ 2'b01;
                rs_data = ~a;
                rt_data = b + 32'd1;
            end else if (k == poke_k + 1) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
        end
        start = 1'b0;
        mthi  = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b1;
        mthi    = 1'b1;
        mtlo    = 1'b1;
        op      = 2'd1;
        rs_data = 32'hFFFF_FFFF;
        rt_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL post_reset_done got %0b want 0", done); end
    endtask

    task automatic test_multu_max();
        int lat, elat;
        logic [31:0] rh, rl, hp, lp, h0, eh, el;
        logic bok, stab;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, rh, rl, hp, lp, h0, bok, stab);
        model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hp, lp, eh, el, elat);
        n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL multu_max_latency got %0d want %0d", lat, elat); end
        n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL multu_max_hi got %h want %h", rh, eh); end
        n_checks++; if (rl !== el) begin n_fail++; $display("FAIL multu_max_lo got %h want %h", rl, el); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL multu_max_busy got %0b want 1", bok); end
        n_checks++; if (stab !== 1'b1) begin n_fail++; $display("FAIL multu_max_hilo_stable got %0b want 1", stab); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_max_done_width got %0b want 0", done); end
    endtask

    task automatic test_mult_ignore_start();
        int lat, elat, extra;
        logic [31:0] rh, rl, hp, lp, h0, eh, el;
        logic bok, stab;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 5, 1'b1, 1'b0, lat, rh, rl, hp, lp, h0, bok, stab);
        model(2'd0, 32'hFFFF_FFFD, 32'd5, hp, lp, eh, el, elat);
        n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL mult_neg_latency got %0d want %0d", lat, elat); end
        n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL mult_neg_hi got %h want %h", rh, eh); end
        n_checks++; if (rl !== el) begin n_fail++; $display("FAIL mult_neg_lo got %h want %h", rl, el); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL mult_neg_busy got %0b want 1", bok); end
        extra = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignored_start_done_pulses got %0d want 0", extra); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_busy got %0b want 0", busy); end
    endtask

    task automatic test_div();
        logic [1:0]  ops [3] = '{2'd2, 2'd2, 2'd3};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [31:0] bs  [3] = '{32'd2, 32'hFFFF_FFFF, 32'd7};
        int lat, elat;
        logic [31:0] rh, rl, hp, lp, h0, eh, el;
        logic bok, stab;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, rh, rl, hp, lp, h0, bok, stab);
            model(ops[i], as[i], bs[i], hp, lp, eh, el, elat);
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL div%0d_latency got %0d want %0d", i, lat, elat); end
            n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL div%0d_hi got %h want %h", i, rh, eh); end
            n_checks++; if (rl !== el) begin n_fail++; $display("FAIL div%0d_lo got %h want %h", i, rl, el); end
            n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL div%0d_busy got %0b want 1", i, bok); end
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  ops [2] = '{2'd3, 2'd2};
        logic [31:0] as  [2] = '{32'd5, 32'hFFFF_FFF7};
        int lat, elat;
        logic [31:0] rh, rl, hp, lp, h0, eh, el;
        logic bok, stab;
        @(negedge clk);
        rs_data = 32'hA5A5_0F0F;
        mthi    = 1'b1;
        mtlo    = 1'b1;
        @(negedge clk);
        mthi    = 1'b0;
        mtlo    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], as[i], 32'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, rh, rl, hp, lp, h0, bok, stab);
            model(ops[i], as[i], 32'd0, hp, lp, eh, el, elat);
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL divzero%0d_latency got %0d want %0d", i, lat, elat); end
            n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL divzero%0d_hi got %h want %h", i, rh, eh); end
            n_checks++; if (rl !== el) begin n_fail++; $display("FAIL divzero%0d_lo got %h want %h", i, rl, el); end
            n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL divzero%0d_busy got %0b want 1", i, bok); end
        end
    endtask

    task automatic test_mthi_mtlo();
        int lat, elat;
        logic [31:0] rh, rl, hp, lp, h0, eh, el, lo_prev;
        logic bok, stab;
        @(negedge clk);
        lo_prev = lo;
        rs_data = 32'h1234_5678;
        mthi    = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_idle got %h want 12345678", hi); end
        n_checks++; if (lo !== lo_prev) begin n_fail++; $display("FAIL mthi_lo_kept got %h want %h", lo, lo_prev); end
        @(negedge clk);
        rs_data = 32'h9ABC_DEF0;
        mtlo    = 1'b1;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        n_checks++; if (lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_idle got %h want 9abcdef0", lo); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi); end
        run_op(2'd1, 32'd7, 32'd9, 1'b0, 1'b0, 3, 1'b0, 1'b1, lat, rh, rl, hp, lp, h0, bok, stab);
        model(2'd1, 32'd7, 32'd9, hp, lp, eh, el, elat);
        n_checks++; if (stab !== 1'b1) begin n_fail++; $display("FAIL mthi_busy_stable got %0b want 1", stab); end
        n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL mthi_busy_hi got %h want %h", rh, eh); end
        n_checks++; if (rl !== el) begin n_fail++; $display("FAIL mthi_busy_lo got %h want %h", rl, el); end
        run_op(2'd0, 32'h0001_0003, 32'hFFFF_0000, 1'b1, 1'b0, -1, 1'b0, 1'b0, lat, rh, rl, hp, lp, h0, bok, stab);
        model(2'd0, 32'h0001_0003, 32'hFFFF_0000, 32'h0001_0003, lp, eh, el, elat);
        n_checks++; if (h0 !== 32'h0001_0003) begin n_fail++; $display("FAIL mthi_with_start_hi got %h want 00010003", h0); end
        n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL mthi_with_start_result_hi got %h want %h", rh, eh); end
        n_checks++; if (rl !== el) begin n_fail++; $display("FAIL mthi_with_start_result_lo got %h want %h", rl, el); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        @(negedge clk);
        rs_data = 32'hDEAD_BEEF;
        mthi    = 1'b1;
        mtlo    = 1'b1;
        @(negedge clk);
        mthi    = 1'b0;
        mtlo    = 1'b0;
        start   = 1'b1;
        op      = 2'd1;
        rs_data = 32'hFFFF_FFFF;
        rt_data = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %0b want 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo got %h want 0", lo); end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_late_done got %0d want 0", pulses); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi_after got %h want 0", hi); end
    endtask

    task automatic test_random();
        int lat, elat;
        logic [31:0] a, b, rh, rl, hp, lp, h0, eh, el, hin;
        logic [1:0] o;
        logic wm, bok, stab;
        for (int i = 0; i < 30; i++) begin
            o  = 2'($urandom_range(0, 3));
            a  = rnd_word();
            b  = rnd_word();
            wm = ($urandom_range(0, 3) == 0);
            run_op(o, a, b, wm, 1'b0, -1, 1'b0, 1'b0, lat, rh, rl, hp, lp, h0, bok, stab);
            hin = wm ? a : hp;
            model(o, a, b, hin, lp, eh, el, elat);
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rand%0d_latency op=%0d got %0d want %0d", i, o, lat, elat); end
            n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, a, b, rh, eh); end
            n_checks++; if (rl !== el) begin n_fail++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, a, b, rl, el); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, elat;
        logic [31:0] a, b, rh, rl, hp, lp, h0, eh, el;
        logic [1:0] o;
        logic bok, stab;
        for (int i = 0; i < 3; i++) begin
            o = 2'($urandom_range(0, 1));
            a = $urandom();
            b = $urandom();
            run_op(o, a, b, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, rh, rl, hp, lp, h0, bok, stab);
            model(o, a, b, hp, lp, eh, el, elat);
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, elat); end
            n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL b2b%0d_hi got %h want %h", i, rh, eh); end
            n_checks++; if (rl !== el) begin n_fail++; $display("FAIL b2b%0d_lo got %h want %h", i, rl, el); end
            n_checks++; if (h0 !== hp) begin n_fail++; $display("FAIL b2b%0d_hi_at_accept got %h want %h", i, h0, hp); end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_ignore_start();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
